timer_contagem: RTL and testbench

- Countdown stage for the oven timer; sits directly downstream of the keypad/timer-control stage.
- Consumes the BCD key digit D, the load strobe loadn and the 1 Hz tick pgt_1Hz.
- Holds a 4-digit BCD MM:SS count, shifts in keyed digits while stopped, and counts down once per second while enabled.
- Drives the display digits and the zero/done flags to the oven control and display stages.

---
 rtl/timer_contagem.sv | 157 +++++++++++++++
 tb/tb_timer_contagem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_contagem.sv
// Oven timer countdown stage: 4-digit BCD MM:SS, keyed digit entry while stopped, 1 Hz countdown while enabled.
// Optional macro TIMER_NORM_EN folds seconds-tens 6..9 into minutes when a run starts.
module timer_contagem #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk100,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       zero,
  output logic       done,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] load_sync_q, tick_sync_q;
  logic load_prev_q, tick_prev_q;
  logic [3:0] so_q, st_q, mo_q, mt_q;
  logic [3:0] so_d, st_d, mo_d, mt_d;
  logic [3:0] dec_so, dec_st, dec_mo, dec_mt;
  logic load_ev, tick_ev, key_ok, shift_nz, dec_zero;

  always_ff @(posedge clk100 or negedge clearn) begin
    if (!clearn) begin
      load_sync_q <= '1;
      tick_sync_q <= '0;
      load_prev_q <= 1'b1;
      tick_prev_q <= 1'b0;
    end else begin
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], loadn};
      tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], pgt_1Hz};
      load_prev_q <= load_sync_q[SYNC_STAGES-1];
      tick_prev_q <= tick_sync_q[SYNC_STAGES-1];
    end
  end

  assign load_ev  = load_prev_q & ~load_sync_q[SYNC_STAGES-1];
  assign tick_ev  = ~tick_prev_q & tick_sync_q[SYNC_STAGES-1];
  assign key_ok   = load_ev && (D <= 4'd9);
  // The outgoing min_tens is dropped, so only the surviving digits decide zero-ness.
  assign shift_nz = |{mo_q, st_q, so_q, D};

  // MM:SS decrement with BCD borrow; only used while the count is nonzero.
  always_comb begin
    dec_so = so_q;
    dec_st = st_q;
    dec_mo = mo_q;
    dec_mt = mt_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else if (st_q != 4'd0) begin
      dec_st = st_q - 4'd1;
      dec_so = 4'd9;
    end else begin
      dec_so = 4'd9;
      dec_st = 4'd5;
      if (mo_q != 4'd0) begin
        dec_mo = mo_q - 4'd1;
      end else begin
        dec_mo = 4'd9;
        dec_mt = mt_q - 4'd1;
      end
    end
  end

  assign dec_zero = ~|{dec_mt, dec_mo, dec_st, dec_so};

  always_comb begin
    state_d = state_q;
    so_d    = so_q;
    st_d    = st_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    case (state_q)
      IDLE: begin
        if (key_ok) begin
          mt_d = mo_q;
          mo_d = st_q;
          st_d = so_q;
          so_d = D;
          if (shift_nz) state_d = SET;
        end
      end
      SET: begin
        if (!enablen) begin
          state_d = RUN;
`ifdef TIMER_NORM_EN
          if ((st_q >= 4'd6) && !((mt_q == 4'd9) && (mo_q == 4'd9))) begin
            st_d = st_q - 4'd6;
            if (mo_q == 4'd9) begin
              mo_d = 4'd0;
              mt_d = mt_q + 4'd1;
            end else begin
              mo_d = mo_q + 4'd1;
            end
          end
`endif
        end else if (key_ok) begin
          mt_d = mo_q;
          mo_d = st_q;
          st_d = so_q;
          so_d = D;
          if (!shift_nz) state_d = IDLE;
        end
      end
      RUN: begin
        if (tick_ev) begin
          so_d = dec_so;
          st_d = dec_st;
          mo_d = dec_mo;
          mt_d = dec_mt;
          if (dec_zero)     state_d = DONE;
          else if (enablen) state_d = SET;
        end else if (enablen) begin
          state_d = SET;
        end
      end
      DONE: begin
        if (enablen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge clearn) begin
    if (!clearn) begin
      state_q <= IDLE;
      so_q    <= 4'd0;
      st_q    <= 4'd0;
      mo_q    <= 4'd0;
      mt_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
    end
  end

  assign sec_ones = so_q;
  assign sec_tens = st_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
  assign zero     = ~|{mt_q, mo_q, st_q, so_q};
  assign done     = (state_q == DONE);
  assign state_o  = state_q;

endmodule

// File: tb/tb_timer_contagem.sv
// Bench for timer_contagem: directed steps then random keys/ticks/enables against a decimal MM:SS model.
module tb_timer_contagem;

  logic       clk100 = 1'b0;
  logic       clearn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1Hz = 1'b0;
  logic       enablen = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       zero, done;
  logic [1:0] state_o;

  timer_contagem #(.SYNC_STAGES(2)) dut (
    .clk100(clk100), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .enablen(enablen), .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .zero(zero), .done(done), .state_o(state_o)
  );

  always #5 clk100 = ~clk100;

  // Model: count as a decimal number MMSS (0..9999); mode 0 idle, 1 set, 2 run, 3 done.
  int m_n = 0;
  int m_mode = 0;
  bit m_en = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, to_bcd(m_n));
    check({tag, "_zero"}, {15'd0, zero}, {15'd0, (m_n == 0)});
    check({tag, "_done"}, {15'd0, done}, {15'd0, (m_mode == 3)});
    check({tag, "_state"}, {14'd0, state_o}, 16'(m_mode));
  endtask

  task automatic m_settle();
    int mm, ss;
    if (m_mode == 3 && m_en) m_mode = 0;
    else if (m_mode == 2 && m_en) m_mode = 1;
    else if (m_mode == 1 && !m_en) begin
      m_mode = 2;
`ifdef TIMER_NORM_EN
      mm = m_n / 100;
      ss = m_n % 100;
      if (ss >= 60 && mm != 99) m_n = (mm + 1) * 100 + (ss - 60);
`endif
    end
  endtask

  task automatic m_tick();
    int mm, ss;
    if (m_mode == 2) begin
      mm = m_n / 100;
      ss = m_n % 100;
      if (ss > 0) ss--;
      else begin
        ss = 59;
        mm--;
      end
      m_n = mm * 100 + ss;
      if (m_n == 0) m_mode = 3;
    end
  endtask

  task automatic press(input int d);
    @(negedge clk100);
    D = 4'(d);
    loadn = 1'b0;
    repeat (4) @(negedge clk100);
    loadn = 1'b1;
    repeat (4) @(negedge clk100);
    if ((m_mode == 0 || m_mode == 1) && d <= 9) begin
      m_n = (m_n * 10 + d) % 10000;
      m_mode = (m_n != 0) ? 1 : 0;
    end
    m_settle();
  endtask

  task automatic tick_pulse();
    @(negedge clk100);
    pgt_1Hz = 1'b1;
    repeat (4) @(negedge clk100);
    pgt_1Hz = 1'b0;
    repeat (4) @(negedge clk100);
    m_tick();
    m_settle();
  endtask

  task automatic set_en(input bit v);
    @(negedge clk100);
    enablen = v;
    repeat (3) @(negedge clk100);
    m_en = v;
    m_settle();
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk100);
    #2 clearn = 1'b0;
    #1;
    m_n = 0;
    m_mode = 0;
    check_all(tag);
    @(negedge clk100);
    clearn = 1'b1;
    @(negedge clk100);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clk100);
    check_all("reset");
    clearn = 1'b1;
    @(negedge clk100);

    press(1); press(2); press(3); press(4);
    check_all("keys_1234");
    press(5);
    check_all("key5_shift");
    press(10);
    check_all("key_invalid");

    async_reset("rst_a");
    press(1); press(0); press(0);
    check_all("load_0100");
    set_en(1'b0);
    check_all("run_0100");
    @(negedge clk100);
    pgt_1Hz = 1'b1;
    @(posedge clk100); @(posedge clk100); #1;
    check("sync_edge2", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0100);
    @(posedge clk100); #1;
    m_tick();
    check("sync_edge3", {min_tens, min_ones, sec_tens, sec_ones}, to_bcd(m_n));
    repeat (4) @(negedge clk100);
    pgt_1Hz = 1'b0;
    repeat (4) @(negedge clk100);
    tick_pulse();
    check_all("tick_0058");

    set_en(1'b1);
    check_all("pause_0058");
    async_reset("rst_b");
    press(1); press(2); press(3);
    set_en(1'b0);
    check_all("run_0123");
    async_reset("rst_mid_run");

    set_en(1'b1);
    press(0); press(2);
    set_en(1'b0);
    tick_pulse();
    check_all("tick_0001");
    tick_pulse();
    check_all("done_0000");
    set_en(1'b1);
    check_all("done_to_idle");
    tick_pulse(); tick_pulse();
    check_all("idle_ticks");

    press(1); press(0);
    set_en(1'b0);
    repeat (3) tick_pulse();
    set_en(1'b1);
    check_all("pause_0007");
    repeat (5) tick_pulse();
    check_all("held_0007");
    press(5);
    check_all("key_0075");
    set_en(1'b0);
    check_all("resume_0075");
    tick_pulse();
    check_all("resume_tick");

    set_en(1'b1);
    async_reset("rst_c");
    press(9); press(0);
    set_en(1'b0);
    check_all("norm_0090");
`ifdef TIMER_NORM_EN
    check("norm_const", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0130);
`else
    check("norm_const", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0090);
`endif
    tick_pulse();
    check_all("norm_tick");

    set_en(1'b1);
    async_reset("rst_d");
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) press($urandom_range(0, 11));
      else if (r <= 6) tick_pulse();
      else set_en(!m_en);
      check_all("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
